// File: rtl/memory_stage.sv
// MEM stage: issues one load/store per instruction on a req/ack data port, registers MEM/WB results.
// Latency: ALU ops 1 cycle, memory ops 2+ cycles; stall holds upstream for every ACCESS cycle.
module memory_stage #(
  parameter int DATA_W      = 24,
  parameter int ADDR_W      = 24,
  parameter int RD_W        = 4,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [DATA_W-1:0] ex_st_data,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              ex_wb_en,
  input  logic [RD_W-1:0]   ex_rd,
  output logic              stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic [DATA_W-1:0] mem_result,
  output logic              wb_valid,
  output logic              wb_en,
  output logic [RD_W-1:0]   wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              bus_err
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam int CNT_W = $clog2(ACK_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                dmem_req_q, dmem_req_d;
  logic                dmem_we_q, dmem_we_d;
  logic [ADDR_W-1:0]   dmem_addr_q, dmem_addr_d;
  logic [DATA_W-1:0]   dmem_wdata_q, dmem_wdata_d;
  logic                pend_wb_en_q, pend_wb_en_d;
  logic [RD_W-1:0]     pend_rd_q, pend_rd_d;
  logic                wb_valid_q, wb_valid_d;
  logic                wb_en_q, wb_en_d;
  logic [RD_W-1:0]     wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0]   wb_data_q, wb_data_d;
  logic                bus_err_q, bus_err_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    dmem_req_d   = dmem_req_q;
    dmem_we_d    = dmem_we_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    pend_wb_en_d = pend_wb_en_q;
    pend_rd_d    = pend_rd_q;
    wb_valid_d   = 1'b0;
    wb_en_d      = 1'b0;
    wb_rd_d      = wb_rd_q;
    wb_data_d    = wb_data_q;
    bus_err_d    = bus_err_q;

    case (state_q)
      IDLE: begin
        if (ex_valid) begin
          if (ex_mem_read || ex_mem_write) begin
            state_d      = ACCESS;
            cnt_d        = '0;
            dmem_req_d   = 1'b1;
            dmem_we_d    = ex_mem_write;
            dmem_addr_d  = ex_alu_result[ADDR_W-1:0];
            dmem_wdata_d = ex_st_data;
            // read+write together behaves as a store, so it never writes a register
            pend_wb_en_d = ex_wb_en & ~ex_mem_write;
            pend_rd_d    = ex_rd;
          end else begin
            wb_valid_d = 1'b1;
            wb_en_d    = ex_wb_en;
            wb_rd_d    = ex_rd;
            wb_data_d  = ex_alu_result;
          end
        end
      end

      ACCESS: begin
        if (dmem_ack) begin
          state_d    = IDLE;
          dmem_req_d = 1'b0;
          wb_valid_d = 1'b1;
          wb_rd_d    = pend_rd_q;
          if (!dmem_we_q) begin
            wb_en_d   = pend_wb_en_q;
            wb_data_d = dmem_rdata;
          end
        end else if (cnt_q == CNT_LAST) begin
          // abort: retire the instruction without a register write and flag the bus
          state_d    = IDLE;
          dmem_req_d = 1'b0;
          bus_err_d  = 1'b1;
          wb_valid_d = 1'b1;
          wb_rd_d    = pend_rd_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      pend_wb_en_q <= 1'b0;
      pend_rd_q    <= '0;
      wb_valid_q   <= 1'b0;
      wb_en_q      <= 1'b0;
      wb_rd_q      <= '0;
      wb_data_q    <= '0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      pend_wb_en_q <= pend_wb_en_d;
      pend_rd_q    <= pend_rd_d;
      wb_valid_q   <= wb_valid_d;
      wb_en_q      <= wb_en_d;
      wb_rd_q      <= wb_rd_d;
      wb_data_q    <= wb_data_d;
      bus_err_q    <= bus_err_d;
    end
  end

  assign stall      = (state_q == ACCESS);
  assign dmem_req   = dmem_req_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wdata = dmem_wdata_q;
  assign wb_valid   = wb_valid_q;
  assign wb_en      = wb_en_q;
  assign wb_rd      = wb_rd_q;
  assign wb_data    = wb_data_q;
  assign mem_result = wb_data_q;
  assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: ALU, load, store, timeout, reset abort, read+write.
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic [23:0] ex_alu_result;
  logic [23:0] ex_st_data;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_wb_en;
  logic [3:0]  ex_rd;
  logic        stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [23:0] dmem_addr;
  logic [23:0] dmem_wdata;
  logic [23:0] dmem_rdata;
  logic        dmem_ack;
  logic [23:0] mem_result;
  logic        wb_valid;
  logic        wb_en;
  logic [3:0]  wb_rd;
  logic [23:0] wb_data;
  logic        bus_err;

  int n_cmp = 0;
  int n_err = 0;

  memory_stage dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_alu_result(ex_alu_result), .ex_st_data(ex_st_data),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_wb_en(ex_wb_en), .ex_rd(ex_rd),
    .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .mem_result(mem_result), .wb_valid(wb_valid), .wb_en(wb_en), .wb_rd(wb_rd),
    .wb_data(wb_data), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // advance one rising edge, then settle so outputs are sampled away from the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ex_idle();
    ex_valid = 0; ex_mem_read = 0; ex_mem_write = 0; ex_wb_en = 0;
  endtask

  task automatic test_reset();
    logic [123:0] got;
    rst_n = 0;
    tick(); tick();
    got = {stall, dmem_req, dmem_we, dmem_addr, dmem_wdata, mem_result,
           wb_valid, wb_en, wb_rd, wb_data, bus_err};
    n_cmp++;
    if (got !== '0) begin
      n_err++; $display("FAIL reset_outputs: got %h want 0", got);
    end
    rst_n = 1;
    tick();
    n_cmp++;
    if ({stall, dmem_req, wb_valid} !== 3'b000) begin
      n_err++; $display("FAIL post_reset_idle: got %b want 000", {stall, dmem_req, wb_valid});
    end
  endtask

  task automatic test_alu();
    ex_valid = 1; ex_alu_result = 24'h000015; ex_rd = 4'd3; ex_wb_en = 1;
    #1;
    n_cmp++;
    if (stall !== 1'b0) begin
      n_err++; $display("FAIL alu_no_stall: got %b want 0", stall);
    end
    tick();
    ex_idle();
    n_cmp++;
    if ({wb_valid, wb_en, wb_rd, wb_data, mem_result, stall} !== {1'b1, 1'b1, 4'd3, 24'h000015, 24'h000015, 1'b0}) begin
      n_err++; $display("FAIL alu_retire: got v=%b en=%b rd=%0d data=%h res=%h stall=%b want 1 1 3 000015 000015 0",
                        wb_valid, wb_en, wb_rd, wb_data, mem_result, stall);
    end
    tick();
    n_cmp++;
    if ({wb_valid, wb_en, wb_data} !== {1'b0, 1'b0, 24'h000015}) begin
      n_err++; $display("FAIL alu_bubble: got v=%b en=%b data=%h want 0 0 000015", wb_valid, wb_en, wb_data);
    end
  endtask

  task automatic test_load();
    ex_valid = 1; ex_mem_read = 1; ex_alu_result = 24'h000100; ex_rd = 4'd5; ex_wb_en = 1;
    tick();
    // next instruction presented and held while stalled
    ex_mem_read = 0; ex_alu_result = 24'h000077; ex_rd = 4'd7; ex_wb_en = 1;
    for (int c = 1; c <= 3; c++) begin
      if (c == 3) begin
        dmem_ack = 1; dmem_rdata = 24'h00ABCD;
      end
      n_cmp++;
      if ({dmem_req, dmem_we, dmem_addr, stall, wb_valid} !== {1'b1, 1'b0, 24'h000100, 1'b1, 1'b0}) begin
        n_err++; $display("FAIL load_access_c%0d: got req=%b we=%b addr=%h stall=%b v=%b want 1 0 000100 1 0",
                          c, dmem_req, dmem_we, dmem_addr, stall, wb_valid);
      end
      if (c < 3) tick();
    end
    tick();
    dmem_ack = 0;
    n_cmp++;
    if ({wb_valid, wb_en, wb_rd, wb_data, mem_result, dmem_req, stall} !==
        {1'b1, 1'b1, 4'd5, 24'h00ABCD, 24'h00ABCD, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL load_retire: got v=%b en=%b rd=%0d data=%h res=%h req=%b stall=%b want 1 1 5 00abcd 00abcd 0 0",
                        wb_valid, wb_en, wb_rd, wb_data, mem_result, dmem_req, stall);
    end
    tick();
    ex_idle();
    n_cmp++;
    if ({wb_valid, wb_en, wb_rd, wb_data} !== {1'b1, 1'b1, 4'd7, 24'h000077}) begin
      n_err++; $display("FAIL load_held_accept: got v=%b en=%b rd=%0d data=%h want 1 1 7 000077",
                        wb_valid, wb_en, wb_rd, wb_data);
    end
  endtask

  task automatic test_store();
    ex_valid = 1; ex_mem_write = 1; ex_alu_result = 24'h000020; ex_st_data = 24'h00000A; ex_rd = 4'd1; ex_wb_en = 0;
    tick();
    ex_idle();
    dmem_ack = 1;
    n_cmp++;
    if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, stall} !== {1'b1, 1'b1, 24'h000020, 24'h00000A, 1'b1}) begin
      n_err++; $display("FAIL store_access: got req=%b we=%b addr=%h wdata=%h stall=%b want 1 1 000020 00000a 1",
                        dmem_req, dmem_we, dmem_addr, dmem_wdata, stall);
    end
    tick();
    dmem_ack = 0;
    n_cmp++;
    if ({wb_valid, wb_en, wb_data, dmem_req, stall} !== {1'b1, 1'b0, 24'h000077, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL store_retire: got v=%b en=%b data=%h req=%b stall=%b want 1 0 000077 0 0",
                        wb_valid, wb_en, wb_data, dmem_req, stall);
    end
  endtask

  task automatic test_timeout();
    ex_valid = 1; ex_mem_read = 1; ex_alu_result = 24'h000300; ex_rd = 4'd9; ex_wb_en = 1;
    tick();
    ex_idle();
    for (int c = 1; c <= 16; c++) begin
      n_cmp++;
      if ({dmem_req, stall, bus_err, wb_valid} !== 4'b1100) begin
        n_err++; $display("FAIL timeout_wait_c%0d: got req=%b stall=%b err=%b v=%b want 1 1 0 0",
                          c, dmem_req, stall, bus_err, wb_valid);
      end
      tick();
    end
    n_cmp++;
    if ({dmem_req, stall, bus_err, wb_valid, wb_en, wb_data} !== {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 24'h000077}) begin
      n_err++; $display("FAIL timeout_abort: got req=%b stall=%b err=%b v=%b en=%b data=%h want 0 0 1 1 0 000077",
                        dmem_req, stall, bus_err, wb_valid, wb_en, wb_data);
    end
    ex_valid = 1; ex_alu_result = 24'h000042; ex_rd = 4'd2; ex_wb_en = 1;
    tick();
    ex_idle();
    n_cmp++;
    if ({wb_valid, wb_en, wb_rd, wb_data, bus_err} !== {1'b1, 1'b1, 4'd2, 24'h000042, 1'b1}) begin
      n_err++; $display("FAIL timeout_then_alu: got v=%b en=%b rd=%0d data=%h err=%b want 1 1 2 000042 1",
                        wb_valid, wb_en, wb_rd, wb_data, bus_err);
    end
  endtask

  task automatic test_reset_mid_access();
    logic [123:0] got;
    ex_valid = 1; ex_mem_read = 1; ex_alu_result = 24'h000400; ex_rd = 4'd4; ex_wb_en = 1;
    tick();
    ex_idle();
    tick();
    rst_n = 0;
    tick();
    got = {stall, dmem_req, dmem_we, dmem_addr, dmem_wdata, mem_result,
           wb_valid, wb_en, wb_rd, wb_data, bus_err};
    n_cmp++;
    if (got !== '0) begin
      n_err++; $display("FAIL reset_mid_outputs: got %h want 0", got);
    end
    rst_n = 1;
    tick();
    dmem_ack = 1; dmem_rdata = 24'h123456;
    tick();
    dmem_ack = 0;
    n_cmp++;
    if ({wb_valid, wb_en, wb_data, dmem_req, stall} !== {1'b0, 1'b0, 24'h000000, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL reset_late_ack: got v=%b en=%b data=%h req=%b stall=%b want 0 0 000000 0 0",
                        wb_valid, wb_en, wb_data, dmem_req, stall);
    end
  endtask

  task automatic test_read_write_both();
    ex_valid = 1; ex_mem_read = 1; ex_mem_write = 1; ex_wb_en = 1;
    ex_alu_result = 24'h000050; ex_st_data = 24'h00000B; ex_rd = 4'd6;
    tick();
    ex_idle();
    dmem_ack = 1; dmem_rdata = 24'hFFFFFF;
    n_cmp++;
    if ({dmem_req, dmem_we, dmem_addr, dmem_wdata} !== {1'b1, 1'b1, 24'h000050, 24'h00000B}) begin
      n_err++; $display("FAIL rw_access: got req=%b we=%b addr=%h wdata=%h want 1 1 000050 00000b",
                        dmem_req, dmem_we, dmem_addr, dmem_wdata);
    end
    tick();
    dmem_ack = 0;
    n_cmp++;
    if ({wb_valid, wb_en, wb_data} !== {1'b1, 1'b0, 24'h000000}) begin
      n_err++; $display("FAIL rw_retire: got v=%b en=%b data=%h want 1 0 000000", wb_valid, wb_en, wb_data);
    end
  endtask

  initial begin
    rst_n = 0;
    ex_idle();
    ex_alu_result = '0; ex_st_data = '0; ex_rd = '0;
    dmem_rdata = '0; dmem_ack = 0;
    #2;
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_timeout();
    test_reset_mid_access();
    test_read_write_both();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
